// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path constants for the RISC-V decoder and its pipeline registers.
// Holds the writeback-select encodings, bubble field values and opcode map.
package riscv_ctrl_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // A bubble is a slot with every enable low and writeback selecting the ALU.
    localparam logic       BUBBLE_EN  = 1'b0;
    localparam logic [1:0] BUBBLE_RES = RES_ALU;

    localparam int RD_W_DEF   = 5;
    localparam int ALUC_W_DEF = 3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline boundary register for a packed control bundle.
// Async clear and synchronous clear both load the BUBBLE constant; en low holds.
module ctrl_stage_reg #(
    parameter int              W      = 8,
    parameter logic [W-1:0]    BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] bundle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= BUBBLE;
        end else if (en_i) begin
            bundle_q <= clr_i ? BUBBLE : d_i;
        end
    end

    assign q_o = bundle_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control fields through ID/EX, EX/MEM and MEM/WB with flush and stall,
// and resolves the EX-stage fetch redirect.
module ctrl_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int RD_W   = RD_W_DEF,
    parameter int ALUC_W = ALUC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [RD_W-1:0]   RdD,
    input  logic              IllegalD,
    input  logic              FlushE,
    input  logic              StallAll,
    input  logic              ZeroE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [RD_W-1:0]   RdE,
    output logic              PCSrcE,
    output logic              IllegalE,
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              MemWriteM,
    output logic [RD_W-1:0]   RdM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [RD_W-1:0]   RdW
);

    localparam int EW = 8 + ALUC_W + RD_W;
    localparam int MW = 4 + RD_W;
    localparam int WW = 3 + RD_W;

    localparam logic [EW-1:0] E_BUBBLE = {BUBBLE_EN, BUBBLE_RES, BUBBLE_EN, BUBBLE_EN, BUBBLE_EN,
                                          BUBBLE_EN, {ALUC_W{1'b0}}, {RD_W{1'b0}}, 1'b0};
    localparam logic [EW-1:0] E_ILLEGAL = {E_BUBBLE[EW-1:1], 1'b1};
    localparam logic [MW-1:0] M_BUBBLE = {BUBBLE_EN, BUBBLE_RES, BUBBLE_EN, {RD_W{1'b0}}};
    localparam logic [WW-1:0] W_BUBBLE = {BUBBLE_EN, BUBBLE_RES, {RD_W{1'b0}}};

    logic [EW-1:0] e_d, e_q;
    logic [MW-1:0] m_d, m_q;
    logic [WW-1:0] w_d, w_q;
    logic          jumpE, branchE;
    logic          advance;

    assign advance = ~StallAll;

    // An illegal slot selects a constant bundle so decoder X never reaches the register.
    always_comb begin
        e_d = E_BUBBLE;
        if (IllegalD) begin
            e_d = E_ILLEGAL;
        end else begin
            e_d = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
                   ALUControlD, RdD, 1'b0};
        end
    end

    ctrl_stage_reg #(.W(EW), .BUBBLE(E_BUBBLE)) u_reg_e (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (advance),
        .clr_i (FlushE),
        .d_i   (e_d),
        .q_o   (e_q)
    );

    assign {RegWriteE, ResultSrcE, MemWriteE, jumpE, branchE, ALUSrcE,
            ALUControlE, RdE, IllegalE} = e_q;

    assign m_d = {RegWriteE, ResultSrcE, MemWriteE, RdE};

    ctrl_stage_reg #(.W(MW), .BUBBLE(M_BUBBLE)) u_reg_m (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (advance),
        .clr_i (1'b0),
        .d_i   (m_d),
        .q_o   (m_q)
    );

    assign {RegWriteM, ResultSrcM, MemWriteM, RdM} = m_q;

    assign w_d = {RegWriteM, ResultSrcM, RdM};

    ctrl_stage_reg #(.W(WW), .BUBBLE(W_BUBBLE)) u_reg_w (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (advance),
        .clr_i (1'b0),
        .d_i   (w_d),
        .q_o   (w_q)
    );

    assign {RegWriteW, ResultSrcW, RdW} = w_q;

    // Bubbles carry Jump/Branch low, so the redirect is inherently suppressed for them.
    assign PCSrcE = jumpE | (branchE & ZeroE);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: W-stage scoreboard plus constant checks on E/M outputs,
// covering reset, streaming, branch/jump, flush, stall priority and illegal slots.
module tb_ctrl_pipe;
    import riscv_ctrl_pkg::*;

    localparam int RD_W   = 5;
    localparam int ALUC_W = 3;

    logic              clk;
    logic              rst_n;
    logic              RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD;
    logic [1:0]        ResultSrcD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [RD_W-1:0]   RdD;
    logic              FlushE, StallAll, ZeroE;
    logic              RegWriteE, MemWriteE, ALUSrcE, PCSrcE, IllegalE;
    logic [1:0]        ResultSrcE, ResultSrcM, ResultSrcW;
    logic [ALUC_W-1:0] ALUControlE;
    logic [RD_W-1:0]   RdE, RdM, RdW;
    logic              RegWriteM, MemWriteM, RegWriteW;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] lastW;

    ctrl_pipe #(.RD_W(RD_W), .ALUC_W(ALUC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ALUControlD (ALUControlD),
        .RdD         (RdD),
        .IllegalD    (IllegalD),
        .FlushE      (FlushE),
        .StallAll    (StallAll),
        .ZeroE       (ZeroE),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .RdE         (RdE),
        .PCSrcE      (PCSrcE),
        .IllegalE    (IllegalE),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .MemWriteM   (MemWriteM),
        .RdM         (RdM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RdW         (RdW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE, RdE, PCSrcE,
                          IllegalE, RegWriteM, ResultSrcM, MemWriteM, RdM, RegWriteW,
                          ResultSrcW, RdW}, 32'h0);
    endtask

    task automatic applyStimulus(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic j, input logic b, input logic as,
                                 input logic [2:0] aluc, input logic [4:0] rd);
        RegWriteD   = rw;
        ResultSrcD  = rs;
        MemWriteD   = mw;
        JumpD       = j;
        BranchD     = b;
        ALUSrcD     = as;
        ALUControlD = aluc;
        RdD         = rd;
        IllegalD    = 1'b0;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    endtask

    task automatic resetScoreboard();
        sb.delete();
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        lastW = 8'h00;
    endtask

    // One rising edge; the bundle entering now is expected at W two unstalled edges later.
    task automatic tick();
        logic [7:0] expW;
        logic       stalled;
        expW    = (FlushE || IllegalD) ? 8'h00 : {RegWriteD, ResultSrcD, RdD};
        stalled = StallAll;
        @(posedge clk);
        #1;
        if (!stalled) begin
            sb.push_back(expW);
            lastW = sb.pop_front();
        end
        checkOutput("sb_W", {24'h0, RegWriteW, ResultSrcW, RdW}, {24'h0, lastW});
    endtask

    initial begin
        rst_n    = 1'b0;
        FlushE   = 1'b0;
        StallAll = 1'b0;
        ZeroE    = 1'b0;
        applyNop();
        RegWriteD = 1'b1;
        RdD       = 5'd5;
        resetScoreboard();
        #3;
        checkAllZero("reset_initial");
        @(posedge clk);
        #1;
        checkAllZero("reset_no_capture");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming LW then SW
        applyStimulus(1'b1, RES_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd7);
        tick();
        checkOutput("lw_E", {RegWriteE, ResultSrcE, ALUSrcE, RdE}, {1'b1, RES_MEM, 1'b1, 5'd7});
        applyStimulus(1'b0, RES_ALU, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0);
        tick();
        checkOutput("lw_M", {ResultSrcM, RdM}, {RES_MEM, 5'd7});
        checkOutput("sw_E", MemWriteE, 1'b1);
        applyNop();
        tick();
        checkOutput("sw_M", MemWriteM, 1'b1);
        checkOutput("lw_W", {RegWriteW, RdW}, {1'b1, 5'd7});

        // Branch and jump resolution
        applyStimulus(1'b0, RES_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 5'd0);
        tick();
        ZeroE = 1'b1;
        #1;
        checkOutput("beq_taken", PCSrcE, 1'b1);
        ZeroE = 1'b0;
        #1;
        checkOutput("beq_not_taken", PCSrcE, 1'b0);
        applyStimulus(1'b1, RES_PC4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd1);
        tick();
        checkOutput("jal_zero0", PCSrcE, 1'b1);
        ZeroE = 1'b1;
        #1;
        checkOutput("jal_zero1", PCSrcE, 1'b1);
        applyNop();
        tick();
        checkOutput("nop_pcsrc", PCSrcE, 1'b0);
        ZeroE = 1'b0;

        // Flush an R-type
        applyStimulus(1'b1, RES_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd3);
        FlushE = 1'b1;
        tick();
        checkOutput("flush_E", {RegWriteE, RdE, PCSrcE, ALUControlE}, 32'h0);
        FlushE = 1'b0;
        applyNop();
        tick();
        tick();
        checkOutput("flush_W", {RegWriteW, RdW}, 32'h0);

        // Stall has priority over flush
        applyStimulus(1'b1, RES_PC4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9);
        tick();
        applyStimulus(1'b1, RES_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd12);
        tick();
        applyStimulus(1'b1, RES_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd15);
        StallAll = 1'b1;
        FlushE   = 1'b1;
        tick();
        tick();
        checkOutput("stall_E", {RegWriteE, RdE}, {1'b1, 5'd12});
        checkOutput("stall_M", {RegWriteM, ResultSrcM, RdM}, {1'b1, RES_PC4, 5'd9});
        StallAll = 1'b0;
        FlushE   = 1'b0;
        tick();
        checkOutput("resume_E", {RegWriteE, ResultSrcE, RdE}, {1'b1, RES_MEM, 5'd15});
        checkOutput("resume_M", RdM, 5'd12);
        checkOutput("resume_W", {RegWriteW, RdW}, {1'b1, 5'd9});

        // Illegal slot with X on the rest of the bundle
        RegWriteD   = 1'bx;
        ResultSrcD  = 2'bxx;
        MemWriteD   = 1'bx;
        JumpD       = 1'bx;
        BranchD     = 1'bx;
        ALUSrcD     = 1'bx;
        ALUControlD = 'x;
        RdD         = 'x;
        IllegalD    = 1'b1;
        ZeroE       = 1'b1;
        tick();
        checkOutput("ill_E", {RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE, RdE,
                              PCSrcE, IllegalE}, 32'h1);
        ZeroE = 1'b0;
        applyNop();
        tick();
        checkOutput("ill_clear", IllegalE, 1'b0);
        checkOutput("ill_M", {RegWriteM, ResultSrcM, MemWriteM, RdM}, 32'h0);
        IllegalD = 1'b1;
        FlushE   = 1'b1;
        tick();
        checkOutput("ill_flushed", IllegalE, 1'b0);
        IllegalD = 1'b0;
        FlushE   = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, RES_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5);
        tick();
        tick();
        checkOutput("pre_reset_M", {RegWriteM, RdM}, {1'b1, 5'd5});
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_async");
        resetScoreboard();
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, RES_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd21);
        tick();
        applyNop();
        tick();
        checkOutput("post_reset_W2", RegWriteW, 1'b0);
        tick();
        checkOutput("post_reset_W3", {RegWriteW, ResultSrcW, RdW}, {1'b1, RES_MEM, 5'd21});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
